// File: rtl/lsu_mem_access_if.sv
// rtl/lsu_mem_access_if.sv - request, data-memory and response signals of the load/store access stage
interface lsu_mem_access_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        opcode;
  logic [ADDR_W-1:0] eff_addr;
  logic [DATA_W-1:0] store_data;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (
    input  req_valid, opcode, eff_addr, store_data, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata,
           resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    output req_valid, opcode, eff_addr, store_data, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata,
           resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/lsu_mem_access.sv
// rtl/lsu_mem_access.sv - lw/sw alignment check and single-outstanding data-memory handshake
module lsu_mem_access #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  lsu_mem_access_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.resp_valid <= 1'b0;
          if (bus.req_valid) begin
            if (bus.opcode[1] && bus.eff_addr[1:0] == 2'b00) begin
              bus.mem_addr  <= ADDR_W'(bus.eff_addr);
              bus.mem_we    <= bus.opcode[0];
              bus.mem_wdata <= bus.opcode[0] ? DATA_W'(bus.store_data) : DATA_W'(0);
              bus.mem_req   <= 1'b1;
              cnt           <= '0;
              state         <= ACCESS;
            end else begin
              // ALU ops complete cleanly; misaligned lw/sw report an error without touching memory
              bus.resp_err   <= bus.opcode[1];
              bus.resp_rdata <= '0;
              bus.resp_valid <= 1'b1;
              state          <= DONE;
            end
          end
        end
        ACCESS: begin
          // ack is checked first so an ack on the final allowed cycle is not reported as a timeout
          if (bus.mem_ack) begin
            bus.mem_req    <= 1'b0;
            bus.resp_rdata <= bus.mem_we ? DATA_W'(0) : DATA_W'(bus.mem_rdata);
            bus.resp_err   <= 1'b0;
            bus.resp_valid <= 1'b1;
            state          <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            bus.mem_req    <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b1;
            bus.resp_valid <= 1'b1;
            state          <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          bus.resp_valid <= 1'b0;
          state          <= IDLE;
        end
        default: begin
          bus.resp_valid <= 1'b0;
          bus.mem_req    <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_access.sv
// tb/tb_lsu_mem_access.sv - scoreboard bench for lsu_mem_access with directed lw/sw/alu vectors
module tb_lsu_mem_access;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  lsu_mem_access_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_mem_access #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    req_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Response monitor: every resp_valid sample must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=resp_valid required=no_response");
      end else begin
        resp_t r;
        r = exp_q.pop_front();
        chk("resp_rdata", bus.resp_rdata, r.rdata);
        chk("resp_err", {31'b0, bus.resp_err}, {31'b0, r.err});
      end
    end
  end

  always @(negedge clk) if (bus.mem_req) req_cycles++;

  // ack_dly: edge (counted from accept) at which mem_ack is sampled; 0 = never
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input int ack_dly, input logic [31:0] rdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input bit exp_mem,
                        input int exp_req_cycles);
    resp_t r;
    int n;
    r.rdata = exp_rdata;
    r.err   = exp_err;
    exp_q.push_back(r);
    bus.req_valid  = 1'b1;
    bus.opcode     = op;
    bus.eff_addr   = addr;
    bus.store_data = sdata;
    req_cycles     = 0;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.store_data = 32'h0;
    chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
    if (exp_mem) begin
      chk({tag, "_mem_req"}, {31'b0, bus.mem_req}, 32'd1);
      chk({tag, "_mem_we"}, {31'b0, bus.mem_we}, {31'b0, op[0]});
      chk({tag, "_mem_addr"}, bus.mem_addr, addr);
      chk({tag, "_mem_wdata"}, bus.mem_wdata, op[0] ? sdata : 32'h0);
      if (ack_dly > 0) begin
        repeat (ack_dly - 1) begin @(posedge clk); #1; end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        @(posedge clk); #1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hA5A5_A5A5;
      end
    end else begin
      chk({tag, "_no_mem_req"}, {31'b0, bus.mem_req}, 32'd0);
      chk({tag, "_resp_next_cycle"}, {31'b0, bus.resp_valid}, 32'd1);
    end
    n = 0;
    while (!bus.req_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_ready_back"}, {31'b0, bus.req_ready}, 32'd1);
    chk({tag, "_req_cycles"}, req_cycles, exp_req_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.opcode     = 2'b00;
    bus.eff_addr   = 32'h0;
    bus.store_data = 32'h0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'hA5A5_A5A5;
    rst_n          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);

    run_op("lw_ok", 2'b10, 32'h0000_0010, 32'hFFFF_FFFF, 3, 32'hDEAD_BEEF,
           32'hDEAD_BEEF, 1'b0, 1'b1, 3);
    run_op("sw_ok", 2'b11, 32'h0000_0024, 32'h1234_5678, 1, 32'hCAFE_F00D,
           32'h0, 1'b0, 1'b1, 1);
    run_op("lw_misal", 2'b10, 32'h0000_0013, 32'h0, 0, 32'h0,
           32'h0, 1'b1, 1'b0, 0);
    run_op("sw_misal", 2'b11, 32'h0000_0042, 32'h5555_AAAA, 0, 32'h0,
           32'h0, 1'b1, 1'b0, 0);
    run_op("add", 2'b00, 32'h0000_0013, 32'h0, 0, 32'h0,
           32'h0, 1'b0, 1'b0, 0);
    run_op("sw_timeout", 2'b11, 32'h0000_0040, 32'h0BAD_0BAD, 0, 32'h0,
           32'h0, 1'b1, 1'b1, 16);
    run_op("sw_ack_last", 2'b11, 32'h0000_0040, 32'h0BAD_0BAD, 16, 32'h0,
           32'h0, 1'b0, 1'b1, 16);
    run_op("lw_ack_last", 2'b10, 32'h0000_0100, 32'h0, 16, 32'h0F0F_1234,
           32'h0F0F_1234, 1'b0, 1'b1, 16);

    // reset during ACCESS: request drops, no response, late ack ignored
    bus.req_valid  = 1'b1;
    bus.opcode     = 2'b11;
    bus.eff_addr   = 32'h0000_0080;
    bus.store_data = 32'h7777_7777;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("midrst_req_before", {31'b0, bus.mem_req}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("midrst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("midrst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    rst_n       = 1'b1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("late_ack_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("late_ack_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("late_ack_resp_valid", {31'b0, bus.resp_valid}, 32'd0);

    run_op("lw_after_rst", 2'b10, 32'h0000_0004, 32'h0, 2, 32'h8000_0001,
           32'h8000_0001, 1'b0, 1'b1, 2);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
